// File: rtl/darkroom_event_fifo_pkg.sv
// Shared definitions for the DarkRoom event FIFO: register map, CTRL/STATUS bit positions
// and drop counter width.
package darkroom_event_fifo_pkg;

    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_DATA    = 2'd1,
        REG_HEAD_ID = 2'd2,
        REG_CTRL    = 2'd3
    } reg_addr_e;

    localparam int unsigned CTRL_FLUSH_BIT  = 0;
    localparam int unsigned CTRL_CLEAR_BIT  = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 2;

    localparam int unsigned STATUS_LEVEL_W       = 16;
    localparam int unsigned STATUS_EMPTY_BIT     = 16;
    localparam int unsigned STATUS_FULL_BIT      = 17;
    localparam int unsigned STATUS_UNDERFLOW_BIT = 18;
    localparam int unsigned STATUS_IRQ_EN_BIT    = 19;
    localparam int unsigned STATUS_DROP_LSB      = 24;

    localparam int unsigned DROP_W   = 8;
    localparam int unsigned DROP_MAX = (1 << DROP_W) - 1;

    function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] cnt,
                                                       input int unsigned inc);
        int unsigned sum;
        sum = 32'(cnt) + inc;
        if (sum > DROP_MAX) begin
            return '1;
        end
        return sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/darkroom_event_fifo_sync_fifo.sv
// Synchronous FIFO with flush; head entry is visible combinationally.
// Pointers carry one extra bit so full and empty are distinguishable.
module darkroom_event_fifo_sync_fifo #(
    parameter int unsigned WIDTH = 42,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign level     = wr_ptr_q - rd_ptr_q;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (level == (AW+1)'(DEPTH));
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is accepted when a pop frees the slot in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/darkroom_event_fifo.sv
// DarkRoom event FIFO: captures per-sensor sweep words, queues them tagged with the sensor
// index through a round-robin arbiter, and exposes the queue to the host over Avalon-MM.
module darkroom_event_fifo
    import darkroom_event_fifo_pkg::*;
#(
    parameter int unsigned NUMBER_OF_SENSORS = 8,
    parameter int unsigned FIFO_DEPTH        = 64,
    parameter int unsigned IRQ_THRESHOLD     = 16,
    parameter int unsigned IDX_W             = 10
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [32*NUMBER_OF_SENSORS-1:0] sample_i,
    input  logic [NUMBER_OF_SENSORS-1:0]    sample_vld_i,
    input  logic [1:0]                      address,
    input  logic                            read,
    input  logic                            write,
    input  logic [31:0]                     writedata,
    output logic [31:0]                     readdata,
    output logic                            waitrequest,
    output logic                            irq_o
);

    localparam int unsigned NOS   = NUMBER_OF_SENSORS;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FW    = 32 + IDX_W;

    logic [31:0]       hold_q [NOS];
    logic [31:0]       hold_d [NOS];
    logic [NOS-1:0]    pend_q, pend_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              underflow_q, underflow_d;
    logic              irq_en_q, irq_en_d;
    logic              irq_q, irq_d;
    logic              ack_q, ack_d;
    logic              pop_pend_q, pop_pend_d;
    logic [31:0]       readdata_q, readdata_d;

    logic [FW-1:0]     f_head;
    logic [LVL_W-1:0]  f_level;
    logic              f_full, f_empty, f_pop, f_push;

    logic              ctrl_wr, flush, clr;
    logic              rd_start, can_push;
    logic              hi_found, lo_found, gnt_vld;
    logic [IDX_W-1:0]  hi_idx, lo_idx, gnt_idx;
    logic [31:0]       hi_word, lo_word, gnt_word;
    logic [NOS-1:0]    gnt_oh;
    int unsigned       drop_inc;
    logic [31:0]       status_word;
    logic              unused_writedata;

    assign unused_writedata = ^writedata;

    assign ctrl_wr  = write & (address == REG_CTRL);
    assign flush    = ctrl_wr & writedata[CTRL_FLUSH_BIT];
    assign clr      = ctrl_wr & writedata[CTRL_CLEAR_BIT];
    assign rd_start = read & ~ack_q;
    assign f_pop    = ack_q & pop_pend_q;
    assign can_push = ~f_full | (f_pop & ~f_empty);
    assign f_push   = gnt_vld;

    darkroom_event_fifo_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (f_push),
        .push_data ({gnt_idx, gnt_word}),
        .pop       (f_pop),
        .flush     (flush),
        .head_data (f_head),
        .level     (f_level),
        .full      (f_full),
        .empty     (f_empty)
    );

    // Round robin: the first pending index above last_q wins, else the lowest pending index.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        hi_word  = '0;
        lo_word  = '0;
        for (int unsigned k = 0; k < NOS; k++) begin
            if (pend_q[k]) begin
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(k);
                    lo_word  = hold_q[k];
                end
                if (!hi_found && (IDX_W'(k) > last_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(k);
                    hi_word  = hold_q[k];
                end
            end
        end
        gnt_vld  = (hi_found | lo_found) & can_push;
        gnt_idx  = hi_found ? hi_idx : lo_idx;
        gnt_word = hi_found ? hi_word : lo_word;
        gnt_oh   = '0;
        for (int unsigned k = 0; k < NOS; k++) begin
            gnt_oh[k] = gnt_vld & (IDX_W'(k) == gnt_idx);
        end
        last_d = gnt_vld ? gnt_idx : last_q;
    end

    // A fresh strobe always lands in hold/pend, even against a same-cycle grant or flush.
    always_comb begin
        pend_d   = flush ? '0 : (pend_q & ~gnt_oh);
        drop_inc = 0;
        for (int unsigned k = 0; k < NOS; k++) begin
            hold_d[k] = flush ? '0 : hold_q[k];
            if (sample_vld_i[k]) begin
                if (pend_q[k] && !gnt_oh[k] && !flush) begin
                    drop_inc = drop_inc + 1;
                end
                hold_d[k] = sample_i[32*k +: 32];
                pend_d[k] = 1'b1;
            end
        end
        drop_d = clr ? '0 : sat_add_drop(drop_q, drop_inc);
    end

    always_comb begin
        status_word                            = '0;
        status_word[STATUS_LEVEL_W-1:0]        = STATUS_LEVEL_W'(f_level);
        status_word[STATUS_EMPTY_BIT]          = f_empty;
        status_word[STATUS_FULL_BIT]           = f_full;
        status_word[STATUS_UNDERFLOW_BIT]      = underflow_q;
        status_word[STATUS_IRQ_EN_BIT]         = irq_en_q;
        status_word[STATUS_DROP_LSB +: DROP_W] = drop_q;
    end

    // Read data is registered in the wait cycle so it is valid when waitrequest drops.
    always_comb begin
        ack_d       = rd_start;
        pop_pend_d  = rd_start & (address == REG_DATA) & ~f_empty;
        underflow_d = clr ? 1'b0 : underflow_q;
        if (rd_start && (address == REG_DATA) && f_empty) begin
            underflow_d = 1'b1;
        end
        irq_en_d    = ctrl_wr ? writedata[CTRL_IRQ_EN_BIT] : irq_en_q;
        irq_d       = irq_en_q & (f_level >= LVL_W'(IRQ_THRESHOLD));
        readdata_d  = readdata_q;
        if (rd_start) begin
            readdata_d = '0;
            case (reg_addr_e'(address))
                REG_STATUS:  readdata_d = status_word;
                REG_DATA:    readdata_d = f_empty ? '0 : f_head[31:0];
                REG_HEAD_ID: if (!f_empty) readdata_d[IDX_W-1:0] = f_head[32 +: IDX_W];
                REG_CTRL:    readdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
                default:     readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NOS; k++) begin
                hold_q[k] <= '0;
            end
            pend_q      <= '0;
            last_q      <= IDX_W'(NOS - 1);
            drop_q      <= '0;
            underflow_q <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            ack_q       <= 1'b0;
            pop_pend_q  <= 1'b0;
            readdata_q  <= '0;
        end else begin
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            last_q      <= last_d;
            drop_q      <= drop_d;
            underflow_q <= underflow_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            ack_q       <= ack_d;
            pop_pend_q  <= pop_pend_d;
            readdata_q  <= readdata_d;
        end
    end

    // Gated by reset_n so an access in flight is abandoned the moment reset asserts.
    assign waitrequest = reset_n & read & ~ack_q;
    assign readdata    = readdata_q;
    assign irq_o       = irq_q;

endmodule
